rgb2gray_sequencer: RTL and testbench

RGB2GRAY_SEQUENCER -- requirements
Module: rgb2gray_sequencer

---
 rtl/rgb2gray_sequencer.sv | 118 +++++++++++
 tb/tb_rgb2gray_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb2gray_sequencer.sv
// rgb2gray_sequencer: feeds RGB pixels byte-serially to a gray converter and streams
// the gray results out with frame counting, end-of-frame marking and timeout detection.
module rgb2gray_sequencer #(
  parameter int PIXELS_PER_FRAME = 4096,
  parameter int TIMEOUT          = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sclr_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  logic [23:0] pix_data_i,
  output logic        cvt_start_o,
  output logic [7:0]  cvt_rgb_o,
  input  logic        cvt_valid_i,
  input  logic [7:0]  cvt_gray_i,
  output logic        gray_valid_o,
  input  logic        gray_ready_i,
  output logic [7:0]  gray_data_o,
  output logic        gray_eof_o,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] pix_cnt_o
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND_R = 3'd1;
  localparam logic [2:0] S_SEND_G = 3'd2;
  localparam logic [2:0] S_SEND_B = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;
  localparam logic [15:0] LAST = 16'(PIXELS_PER_FRAME - 1);
  localparam logic [7:0]  TMO  = 8'(TIMEOUT);

  logic [2:0]  r_state;
  logic [23:0] r_pix;
  logic [7:0]  r_wcnt;
  logic [7:0]  r_gray;
  logic        r_gvalid;
  logic        r_eof;
  logic        r_fdone;
  logic        r_err;
  logic [15:0] r_cnt;
  logic [7:0]  w_wcnt_nx;

  assign w_wcnt_nx    = r_wcnt + 8'd1;
  // ready is gated by rst_i so that every output reads 0 while reset is held
  assign pix_ready_o  = rst_i && (r_state == S_IDLE) && !r_err;
  assign cvt_start_o  = (r_state == S_SEND_R);
  assign cvt_rgb_o    = (r_state == S_SEND_R) ? r_pix[23:16] :
                        (r_state == S_SEND_G) ? r_pix[15:8]  :
                        (r_state == S_SEND_B) ? r_pix[7:0]   : 8'd0;
  assign gray_valid_o = r_gvalid;
  assign gray_data_o  = r_gray;
  assign gray_eof_o   = r_eof;
  assign frame_done_o = r_fdone;
  assign busy_o       = (r_state != S_IDLE);
  assign err_o        = r_err;
  assign pix_cnt_o    = r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_pix    <= '0;
      r_wcnt   <= '0;
      r_gray   <= '0;
      r_gvalid <= 1'b0;
      r_eof    <= 1'b0;
      r_fdone  <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else if (sclr_i) begin
      r_state  <= S_IDLE;
      r_wcnt   <= '0;
      r_gvalid <= 1'b0;
      r_eof    <= 1'b0;
      r_fdone  <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_fdone <= 1'b0;
      case (r_state)
        S_IDLE: if (pix_valid_i && pix_ready_o) begin
          r_pix   <= pix_data_i;
          r_state <= S_SEND_R;
        end
        S_SEND_R: r_state <= S_SEND_G;
        S_SEND_G: r_state <= S_SEND_B;
        S_SEND_B: begin
          r_wcnt  <= '0;
          r_state <= S_WAIT;
        end
        // a result arriving on the timeout cycle still wins
        S_WAIT: if (cvt_valid_i) begin
          r_gray   <= cvt_gray_i;
          r_gvalid <= 1'b1;
          r_eof    <= (r_cnt == LAST);
          r_wcnt   <= '0;
          r_state  <= S_HOLD;
        end else if (w_wcnt_nx == TMO) begin
          r_err   <= 1'b1;
          r_wcnt  <= '0;
          r_state <= S_IDLE;
        end else begin
          r_wcnt <= w_wcnt_nx;
        end
        S_HOLD: if (gray_ready_i) begin
          r_gvalid <= 1'b0;
          r_eof    <= 1'b0;
          r_fdone  <= r_eof;
          r_cnt    <= r_eof ? 16'd0 : r_cnt + 16'd1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rgb2gray_sequencer.sv
// tb_rgb2gray_sequencer: directed checks of the sequencer with a 3-pixel frame and timeout of 4.
module tb_rgb2gray_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        sclr_i = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic        pix_ready_o;
  logic [23:0] pix_data_i = '0;
  logic        cvt_start_o;
  logic [7:0]  cvt_rgb_o;
  logic        cvt_valid_i = 1'b0;
  logic [7:0]  cvt_gray_i = '0;
  logic        gray_valid_o;
  logic        gray_ready_i = 1'b0;
  logic [7:0]  gray_data_o;
  logic        gray_eof_o;
  logic        frame_done_o;
  logic        busy_o;
  logic        err_o;
  logic [15:0] pix_cnt_o;
  int total = 0;
  int bad = 0;

  rgb2gray_sequencer #(.PIXELS_PER_FRAME(3), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sclr_i(sclr_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o), .pix_data_i(pix_data_i),
    .cvt_start_o(cvt_start_o), .cvt_rgb_o(cvt_rgb_o),
    .cvt_valid_i(cvt_valid_i), .cvt_gray_i(cvt_gray_i),
    .gray_valid_o(gray_valid_o), .gray_ready_i(gray_ready_i), .gray_data_o(gray_data_o),
    .gray_eof_o(gray_eof_o), .frame_done_o(frame_done_o), .busy_o(busy_o),
    .err_o(err_o), .pix_cnt_o(pix_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic feed(input logic [23:0] px);
    chk("ready_before", pix_ready_o, 1);
    pix_data_i = px;
    pix_valid_i = 1'b1;
    tick;
    pix_valid_i = 1'b0;
    chk("start_r", cvt_start_o, 1);
    chk("rgb_r", cvt_rgb_o, px[23:16]);
    tick;
    chk("start_g", cvt_start_o, 0);
    chk("rgb_g", cvt_rgb_o, px[15:8]);
    tick;
    chk("start_b", cvt_start_o, 0);
    chk("rgb_b", cvt_rgb_o, px[7:0]);
    tick;
    chk("rgb_wait", cvt_rgb_o, 0);
  endtask

  task automatic push(input logic [23:0] px, input logic [7:0] g, input int wcyc);
    feed(px);
    repeat (wcyc - 1) tick;
    cvt_valid_i = 1'b1;
    cvt_gray_i = g;
    tick;
    cvt_valid_i = 1'b0;
    chk("hold_valid", gray_valid_o, 1);
    chk("hold_data", gray_data_o, g);
  endtask

  initial begin
    #1;
    chk("rst_ready", pix_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", pix_cnt_o, 0);
    chk("rst_err", err_o, 0);
    #11 rst_i = 1'b1;
    #1 chk("rel_ready", pix_ready_o, 1);
    tick;

    // basic pixel, response on second WAIT cycle
    push(24'hFF8040, 8'h9A, 2);
    chk("t1_busy", busy_o, 1);
    chk("t1_eof", gray_eof_o, 0);
    chk("t1_cnt_pre", pix_cnt_o, 0);
    gray_ready_i = 1'b1;
    tick;
    gray_ready_i = 1'b0;
    chk("t1_valid_clr", gray_valid_o, 0);
    chk("t1_cnt", pix_cnt_o, 1);
    chk("t1_fdone", frame_done_o, 0);

    // back-pressure for 10 cycles
    push(24'h102030, 8'h55, 1);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_valid", gray_valid_o, 1);
      chk("bp_data", gray_data_o, 8'h55);
      chk("bp_ready", pix_ready_o, 0);
      chk("bp_busy", busy_o, 1);
    end
    gray_ready_i = 1'b1;
    tick;
    gray_ready_i = 1'b0;
    chk("bp_cnt", pix_cnt_o, 2);

    // full 3-pixel frame after a soft clear
    sclr_i = 1'b1;
    tick;
    sclr_i = 1'b0;
    chk("sclr_cnt", pix_cnt_o, 0);
    for (int k = 0; k < 3; k++) begin
      push(24'h010203 * (k + 1), 8'(8'h20 + k), 1);
      chk("fr_eof", gray_eof_o, (k == 2));
      gray_ready_i = 1'b1;
      tick;
      gray_ready_i = 1'b0;
      chk("fr_fdone", frame_done_o, (k == 2));
      chk("fr_cnt", pix_cnt_o, (k == 2) ? 0 : k + 1);
    end
    tick;
    chk("fr_fdone_end", frame_done_o, 0);

    // timeout with no converter response
    feed(24'h445566);
    tick;
    tick;
    tick;
    chk("to_err_pre", err_o, 0);
    chk("to_busy_pre", busy_o, 1);
    tick;
    chk("to_err", err_o, 1);
    chk("to_busy", busy_o, 0);
    chk("to_ready", pix_ready_o, 0);
    chk("to_cnt", pix_cnt_o, 0);
    tick;
    chk("to_ready2", pix_ready_o, 0);
    sclr_i = 1'b1;
    tick;
    sclr_i = 1'b0;
    chk("to_err_clr", err_o, 0);
    chk("to_ready_clr", pix_ready_o, 1);

    // response on the timeout cycle wins
    push(24'h778899, 8'h77, 4);
    chk("tv_err", err_o, 0);
    gray_ready_i = 1'b1;
    tick;
    gray_ready_i = 1'b0;
    chk("tv_cnt", pix_cnt_o, 1);
    cvt_valid_i = 1'b1;
    cvt_gray_i = 8'h11;
    tick;
    cvt_valid_i = 1'b0;
    chk("idle_cv_valid", gray_valid_o, 0);
    chk("idle_cv_busy", busy_o, 0);
    chk("idle_cv_data", gray_data_o, 8'h77);

    // soft clear beats a simultaneous output handshake
    push(24'h123456, 8'h33, 1);
    gray_ready_i = 1'b1;
    sclr_i = 1'b1;
    tick;
    gray_ready_i = 1'b0;
    sclr_i = 1'b0;
    chk("pri_cnt", pix_cnt_o, 0);
    chk("pri_valid", gray_valid_o, 0);
    chk("pri_fdone", frame_done_o, 0);

    // asynchronous reset in SEND_G
    pix_data_i = 24'hDEADBE;
    pix_valid_i = 1'b1;
    tick;
    pix_valid_i = 1'b0;
    tick;
    chk("ar_rgb_g", cvt_rgb_o, 8'hAD);
    #2 rst_i = 1'b0;
    #1;
    chk("ar_rgb", cvt_rgb_o, 0);
    chk("ar_busy", busy_o, 0);
    chk("ar_ready", pix_ready_o, 0);
    chk("ar_fdone", frame_done_o, 0);
    #2 rst_i = 1'b1;
    tick;
    chk("ar_fdone2", frame_done_o, 0);
    push(24'hAABBCC, 8'h42, 1);
    gray_ready_i = 1'b1;
    tick;
    gray_ready_i = 1'b0;
    chk("ar_cnt", pix_cnt_o, 1);
    chk("ar_data", gray_data_o, 8'h42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
